lc3_memory_interface: RTL
=========================

# lc3_memory_interface

Receiving end of the LC-3 datapath bus: captures Bus into MAR and MDR under control-unit load strobes and runs the memory read/write handshake that refills MDR. MDROut feeds the bus tri-state buffer's MDR input, closing the loop. An optional memory-mapped I/O decoder intercepts keyboard/display register addresses.

## Interface
- ADDR_W, 16, MAR/memory address width
- DATA_W, 16, Bus/MDR/memory data width
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- Bus  in  DATA_W  datapath bus
- ldMAR  in  1  load MAR from Bus
- ldMDR  in  1  load MDR from Bus (only when MIO_EN=0)
- MIO_EN  in  1  request memory access; held by control until R
- R_W  in  1  1=write (MDR→mem[MAR]), 0=read; sampled at access start
- MAROut  out  ADDR_W  MAR contents
- MDROut  out  DATA_W  MDR contents, to bus buffer
- R  out  1  access complete (memory ready)
- mem_req, mem_we  out  1  memory request / write enable
- mem_addr  out  ADDR_W  = MAR
- mem_wdata  out  DATA_W  = MDR
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  memory completes current request
- kbd_valid  in  1  one-cycle keystroke strobe
- kbd_data  in  8  keystroke ASCII
- disp_ready  in  1  display can accept a character
- ddr_valid  out  1  one-cycle display write strobe
- ddr_data  out  8  display character

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: ldMAR → MAR<=Bus; ldMDR && !MIO_EN → MDR<=Bus; both may load same cycle. MIO_EN=1 → latch R_W, go ACCESS (or DONE directly for MMIO hit).
- ACCESS: mem_req=1, mem_we=latched R_W. ldMAR/ldMDR ignored; MAR/MDR frozen (write data stable). On mem_ack: read → MDR<=mem_rdata; go DONE.
- DONE: R=1, mem_req=0. Stay while MIO_EN=1; MIO_EN=0 → IDLE. No back-to-back access without MIO_EN dropping for ≥1 cycle.
- mem_ack outside ACCESS ignored.
- Reset: state IDLE, MAR=0, MDR=0, R=0, mem_req=0, mem_we=0, ddr_valid=0, ddr_data=0, KBSR ready flag=0. Reset mid-access drops mem_req on same edge; pending ack discarded.

## Timing
- Access request seen in IDLE at edge N → mem_req high cycle N+1.
- mem_ack sampled high at edge M (M≥N+1) → MDR updated and R high from M+1.
- Zero-wait memory (ack tied high): R two cycles after MIO_EN asserted.
- MMIO hit: IDLE→DONE in one edge; R high cycle N+1; mem_req never asserted.
- MAROut/MDROut are registers; visible on Bus via buffer the cycle after load.

## Configuration
- MMIO_DECODE_EN defined: addresses xFE00 KBSR, xFE02 KBDR, xFE04 DSR, xFE06 DDR decoded from MAR.
  - kbd_valid → KBDR<=kbd_data, ready flag=1. KBSR read = {flag,15'b0}. KBDR read = {8'b0,KBDR}, clears flag. kbd_valid same cycle as KBDR read: new data captured, flag stays 1.
  - DSR read = {disp_ready,15'b0}. DDR write → ddr_valid=1 one cycle (cycle N+1), ddr_data=MDR[7:0].
  - MMIO writes to KBSR/KBDR/DSR ignored; R still asserted.
- Undefined: no decode, all addresses go to memory; ddr_valid/ddr_data held 0; kbd_*, disp_ready ignored.

## Structure
- Shared package lc3_pkg: state enum (IDLE/ACCESS/DONE), MMIO address constants, DATA_W/ADDR_W defaults.
- One sub-module natural: lc3_mmio_regs (KBDR/flag, DSR mux, DDR strobe), instantiated under MMIO_DECODE_EN.

## Test plan
- Reset: assert reset 2 cycles mid-ACCESS → mem_req=0, R=0, MAR=MDR=0 next cycle.
- Read: ldMAR Bus=x3000, then MIO_EN R_W=0, mem_ack after 3 cycles with x1234 → MDROut=x1234, R high M+1 until MIO_EN drops.
- Write: MAR=x4000, ldMDR Bus=xBEEF, MIO_EN R_W=1 → mem_req=mem_we=1, mem_addr=x4000, mem_wdata=xBEEF held until ack; ldMDR Bus=x0000 during ACCESS has no effect.
- Hold: MIO_EN held 5 cycles after R → exactly one mem_req pulse train, R high throughout DONE.
- MMIO (macro on): kbd_valid data x41, read xFE00 → MDR=x8000; read xFE02 → MDR=x0041, then KBSR read → x0000.
- MMIO display: write xFE06 MDR=x0048 → ddr_valid one cycle, ddr_data=x48, mem_req never high; macro off → same access goes to memory.

Source files
------------

// File: rtl/lc3_memory_interface_pkg.sv
// Shared types for the LC-3 memory interface: FSM states,
// MMIO register addresses and the MMIO address decoder.
package lc3_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  typedef enum logic [2:0] {
    MMIO_NONE,
    MMIO_KBSR,
    MMIO_KBDR,
    MMIO_DSR,
    MMIO_DDR
  } mmio_sel_e;

  function automatic mmio_sel_e mmio_decode(
    input logic [15:0] a
  );
    mmio_sel_e s;
    case (a)
      KBSR_ADDR: s = MMIO_KBSR;
      KBDR_ADDR: s = MMIO_KBDR;
      DSR_ADDR:  s = MMIO_DSR;
      DDR_ADDR:  s = MMIO_DDR;
      default:   s = MMIO_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lc3_memory_interface_if.sv
// Memory-side request/ack bus between the LC-3 memory
// interface (master) and the memory (slave).
interface lc3_memory_interface_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/lc3_memory_interface_mmio_regs.sv
// Keyboard/display device registers (KBSR/KBDR/DSR/DDR),
// used by lc3_memory_interface when MMIO_DECODE_EN is defined.
module lc3_mmio_regs
  import lc3_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  mmio_sel_e         sel_i,
  input  logic              acc_i,
  input  logic              we_i,
  input  logic [7:0]        wdata_i,
  input  logic              kbd_valid_i,
  input  logic [7:0]        kbd_data_i,
  input  logic              disp_ready_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ddr_valid_o,
  output logic [7:0]        ddr_data_o
);

  logic [7:0] kbdr_q;
  logic       flag_q;
  logic       ddr_valid_q;
  logic [7:0] ddr_data_q;
  logic       kbdr_rd;
  logic       ddr_wr;

  assign kbdr_rd = acc_i && !we_i
                && (sel_i == MMIO_KBDR);
  assign ddr_wr  = acc_i && we_i
                && (sel_i == MMIO_DDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      kbdr_q      <= '0;
      flag_q      <= 1'b0;
      ddr_valid_q <= 1'b0;
      ddr_data_q  <= '0;
    end else begin
      ddr_valid_q <= ddr_wr;
      if (ddr_wr) ddr_data_q <= wdata_i;
      // a new keystroke wins over the read-clear
      if (kbd_valid_i) begin
        kbdr_q <= kbd_data_i;
        flag_q <= 1'b1;
      end else if (kbdr_rd) begin
        flag_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    unique case (1'b1)
      sel_i == MMIO_KBSR:
        rdata_o[DATA_W-1] = flag_q;
      sel_i == MMIO_KBDR:
        rdata_o[7:0] = kbdr_q;
      sel_i == MMIO_DSR:
        rdata_o[DATA_W-1] = disp_ready_i;
      default: ;
    endcase
  end

  assign ddr_valid_o = ddr_valid_q;
  assign ddr_data_o  = ddr_data_q;

endmodule

// File: rtl/lc3_memory_interface.sv
// LC-3 MAR/MDR and memory handshake FSM; optional MMIO
// keyboard/display decode enabled by MMIO_DECODE_EN.
module lc3_memory_interface
  import lc3_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] Bus,
  input  logic              ldMAR,
  input  logic              ldMDR,
  input  logic              MIO_EN,
  input  logic              R_W,
  output logic [ADDR_W-1:0] MAROut,
  output logic [DATA_W-1:0] MDROut,
  output logic              R,
  lc3_memory_interface_if.master mif,
  input  logic              kbd_valid,
  input  logic [7:0]        kbd_data,
  input  logic              disp_ready,
  output logic              ddr_valid,
  output logic [7:0]        ddr_data
);

  state_e            state_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;
  logic              r_q;
  logic              req_q;
  logic              we_q;
  logic              rw_q;

  logic              mmio_hit;
  logic              mmio_acc;
  logic [DATA_W-1:0] mmio_rdata;

  assign mmio_acc = (state_q == IDLE)
                 && MIO_EN && mmio_hit;

`ifdef MMIO_DECODE_EN
  mmio_sel_e sel;

  assign sel      = mmio_decode(16'(mar_q));
  assign mmio_hit = (sel != MMIO_NONE);

  lc3_mmio_regs #(
    .DATA_W (DATA_W)
  ) u_mmio (
    .clk          (clk),
    .reset        (reset),
    .sel_i        (sel),
    .acc_i        (mmio_acc),
    .we_i         (R_W),
    .wdata_i      (mdr_q[7:0]),
    .kbd_valid_i  (kbd_valid),
    .kbd_data_i   (kbd_data),
    .disp_ready_i (disp_ready),
    .rdata_o      (mmio_rdata),
    .ddr_valid_o  (ddr_valid),
    .ddr_data_o   (ddr_data)
  );
`else
  logic unused_mmio;

  assign mmio_hit    = 1'b0;
  assign mmio_rdata  = '0;
  assign ddr_valid   = 1'b0;
  assign ddr_data    = '0;
  assign unused_mmio = ^{kbd_valid, kbd_data,
                         disp_ready, mmio_acc};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      r_q     <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      rw_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ldMAR) mar_q <= ADDR_W'(Bus);
          if (ldMDR && !MIO_EN) mdr_q <= Bus;
          if (MIO_EN) begin
            rw_q <= R_W;
            if (mmio_hit) begin
              state_q <= DONE;
              r_q     <= 1'b1;
              if (!R_W) mdr_q <= mmio_rdata;
            end else begin
              state_q <= ACCESS;
              req_q   <= 1'b1;
              we_q    <= R_W;
            end
          end
        end
        ACCESS: begin
          if (mif.mem_ack) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            r_q     <= 1'b1;
            if (!rw_q) mdr_q <= mif.mem_rdata;
          end
        end
        DONE: begin
          if (!MIO_EN) begin
            state_q <= IDLE;
            r_q     <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MAROut        = mar_q;
  assign MDROut        = mdr_q;
  assign R             = r_q;
  assign mif.mem_req   = req_q;
  assign mif.mem_we    = we_q;
  assign mif.mem_addr  = mar_q;
  assign mif.mem_wdata = mdr_q;

endmodule
